// File: rtl/fft_sched_pkg.sv
// Shared types and sizing for the radix-2 DIT FFT butterfly scheduler.
// The transform size N is fixed here; every width below derives from it.
package fft_sched_pkg;

  localparam int N  = 8;
  localparam int L  = $clog2(N);
  localparam int TW = (L > 1) ? L - 1 : 1;
  // k spans 0..N/2-1 and s spans 0..L-1; both need at least one bit when N = 2
  localparam int KW = TW;
  localparam int SW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {
    LOAD,
    ISSUE,
    WAIT,
    UNLOAD
  } state_t;

  function automatic logic [L-1:0] bitrev(input logic [L-1:0] i);
    logic [L-1:0] r;
    for (int b = 0; b < L; b++) r[b] = i[L-1-b];
    return r;
  endfunction

endpackage

// File: rtl/fft_butterfly_scheduler_if.sv
// Stream, twiddle-ROM and butterfly handshakes of the FFT scheduler.
// master is the scheduler side, slave is the surrounding front end / butterfly / ROM.
interface fft_butterfly_scheduler_if
  import fft_sched_pkg::*;
#(
  parameter int n = 32
);

  logic          in_val;
  logic          in_rdy;
  logic [n-1:0]  in_r;
  logic [n-1:0]  in_c;

  logic          out_val;
  logic          out_rdy;
  logic [n-1:0]  out_r;
  logic [n-1:0]  out_c;

  logic [TW-1:0] tw_idx;
  logic [n-1:0]  tw_r;
  logic [n-1:0]  tw_c;

  logic          bf_recv_val;
  logic          bf_recv_rdy;
  logic [n-1:0]  bf_ar;
  logic [n-1:0]  bf_ac;
  logic [n-1:0]  bf_br;
  logic [n-1:0]  bf_bc;
  logic [n-1:0]  bf_wr;
  logic [n-1:0]  bf_wc;

  logic          bf_send_val;
  logic          bf_send_rdy;
  logic [n-1:0]  bf_cr;
  logic [n-1:0]  bf_cc;
  logic [n-1:0]  bf_dr;
  logic [n-1:0]  bf_dc;

  modport master (
    input  in_val, in_r, in_c,
    output in_rdy,
    output out_val, out_r, out_c,
    input  out_rdy,
    output tw_idx,
    input  tw_r, tw_c,
    output bf_recv_val, bf_ar, bf_ac, bf_br, bf_bc, bf_wr, bf_wc,
    input  bf_recv_rdy,
    input  bf_send_val, bf_cr, bf_cc, bf_dr, bf_dc,
    output bf_send_rdy
  );

  modport slave (
    output in_val, in_r, in_c,
    input  in_rdy,
    input  out_val, out_r, out_c,
    output out_rdy,
    input  tw_idx,
    output tw_r, tw_c,
    input  bf_recv_val, bf_ar, bf_ac, bf_br, bf_bc, bf_wr, bf_wc,
    output bf_recv_rdy,
    output bf_send_val, bf_cr, bf_cc, bf_dr, bf_dc,
    input  bf_send_rdy
  );

endinterface

// File: rtl/fft_sched_addr_gen.sv
// Combinational in-place DIT addressing: (stage s, butterfly k) -> (top, bot, tw_idx).
module fft_sched_addr_gen
  import fft_sched_pkg::*;
(
  input  logic [SW-1:0] s,
  input  logic [KW-1:0] k,
  output logic [L-1:0]  top,
  output logic [L-1:0]  bot,
  output logic [TW-1:0] tw_idx
);

  logic [L-1:0] kk;
  logic [L-1:0] h;
  logic [L-1:0] j;
  logic [L-1:0] tw_full;

  // NOTE: every always_comb output is assigned on every pass, so no latch can form.
  always_comb begin
    kk      = L'(k);
    h       = L'(1) << s;
    j       = kk & (h - L'(1));
    // group index (k >> s) spaced by 2h, then offset j inside the group
    top     = ((kk >> s) << (int'(s) + 1)) | j;
    bot     = top | h;
    tw_full = j << (L - 1 - int'(s));
    tw_idx  = TW'(tw_full);
  end

endmodule

// File: rtl/fft_butterfly_scheduler.sv
// In-place radix-2 DIT FFT controller sharing one external butterfly across the transform.
// Define FFT_SCHED_SCALE_EN to halve every written-back component (output = DFT/N).
module fft_butterfly_scheduler
  import fft_sched_pkg::*;
#(
  parameter int n = 32
) (
  input logic                       clk,
  input logic                       reset,
  fft_butterfly_scheduler_if.master bus
);

  function automatic logic [n-1:0] wb_scale(input logic [n-1:0] v);
`ifdef FFT_SCHED_SCALE_EN
    return {v[n-1], v[n-1:1]};
`else
    return v;
`endif
  endfunction

  logic [n-1:0]  mem_r [N];
  logic [n-1:0]  mem_c [N];

  state_t        state;
  logic [L-1:0]  cnt;
  logic [SW-1:0] s;
  logic [KW-1:0] k;
  logic          in_rdy_q;
  logic          out_val_q;
  logic          recv_val_q;
  logic          send_rdy_q;

  logic [L-1:0]  top;
  logic [L-1:0]  bot;
  logic [TW-1:0] tw_gen;

  logic          in_hs;
  logic          out_hs;
  logic          issue_hs;
  logic          wb_hs;
  logic          last_cnt;
  logic          last_k;
  logic          last_s;

  fft_sched_addr_gen u_addr_gen (
    .s      (s),
    .k      (k),
    .top    (top),
    .bot    (bot),
    .tw_idx (tw_gen)
  );

  assign in_hs    = bus.in_val & in_rdy_q;
  assign out_hs   = out_val_q & bus.out_rdy;
  assign issue_hs = recv_val_q & bus.bf_recv_rdy;
  assign wb_hs    = bus.bf_send_val & send_rdy_q;
  assign last_cnt = (cnt == L'(N - 1));
  assign last_k   = (k == KW'(N / 2 - 1));
  assign last_s   = (s == SW'(L - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      cnt        <= '0;
      s          <= '0;
      k          <= '0;
      in_rdy_q   <= 1'b1;
      out_val_q  <= 1'b0;
      recv_val_q <= 1'b0;
      send_rdy_q <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_hs) begin
            cnt <= cnt + L'(1);
            if (last_cnt) begin
              state      <= ISSUE;
              cnt        <= '0;
              s          <= '0;
              k          <= '0;
              in_rdy_q   <= 1'b0;
              recv_val_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue_hs) begin
            state      <= WAIT;
            recv_val_q <= 1'b0;
            send_rdy_q <= 1'b1;
          end
        end
        WAIT: begin
          if (wb_hs) begin
            send_rdy_q <= 1'b0;
            if (last_k) begin
              k <= '0;
              if (last_s) begin
                state     <= UNLOAD;
                s         <= '0;
                out_val_q <= 1'b1;
              end else begin
                state      <= ISSUE;
                s          <= s + SW'(1);
                recv_val_q <= 1'b1;
              end
            end else begin
              state      <= ISSUE;
              k          <= k + KW'(1);
              recv_val_q <= 1'b1;
            end
          end
        end
        UNLOAD: begin
          if (out_hs) begin
            cnt <= cnt + L'(1);
            if (last_cnt) begin
              state     <= LOAD;
              cnt       <= '0;
              out_val_q <= 1'b0;
              in_rdy_q  <= 1'b1;
            end
          end
        end
        default: begin
          state      <= LOAD;
          cnt        <= '0;
          in_rdy_q   <= 1'b1;
          out_val_q  <= 1'b0;
          recv_val_q <= 1'b0;
          send_rdy_q <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the sample buffer has no reset; every entry is rewritten by the next load before use.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      mem_r[bitrev(cnt)] <= bus.in_r;
      mem_c[bitrev(cnt)] <= bus.in_c;
    end
    // top and bot always differ, so both results land in the same edge
    if (wb_hs) begin
      mem_r[top] <= wb_scale(bus.bf_cr);
      mem_c[top] <= wb_scale(bus.bf_cc);
      mem_r[bot] <= wb_scale(bus.bf_dr);
      mem_c[bot] <= wb_scale(bus.bf_dc);
    end
  end

  assign bus.in_rdy      = in_rdy_q;
  assign bus.out_val     = out_val_q;
  assign bus.bf_recv_val = recv_val_q;
  assign bus.bf_send_rdy = send_rdy_q;

  // data outputs are zeroed whenever their valid is low
  assign bus.out_r  = out_val_q  ? mem_r[cnt] : '0;
  assign bus.out_c  = out_val_q  ? mem_c[cnt] : '0;
  assign bus.tw_idx = recv_val_q ? tw_gen     : '0;
  assign bus.bf_ar  = recv_val_q ? mem_r[top] : '0;
  assign bus.bf_ac  = recv_val_q ? mem_c[top] : '0;
  assign bus.bf_br  = recv_val_q ? mem_r[bot] : '0;
  assign bus.bf_bc  = recv_val_q ? mem_c[bot] : '0;
  assign bus.bf_wr  = recv_val_q ? bus.tw_r   : '0;
  assign bus.bf_wc  = recv_val_q ? bus.tw_c   : '0;

endmodule

// File: tb/tb_fft_butterfly_scheduler.sv
// Directed bench for fft_butterfly_scheduler (N = 8, n = 32, d = 16) with a butterfly/ROM model.
module tb_fft_butterfly_scheduler;
  import fft_sched_pkg::*;

  localparam int  NW  = 32;
  localparam int  D   = 16;
  localparam real TOL = 64.0;
`ifdef FFT_SCHED_SCALE_EN
  localparam logic [31:0] IMP_R = 32'h0000_2000;
  localparam logic [31:0] DC_0  = 32'h0001_0000;
`else
  localparam logic [31:0] IMP_R = 32'h0001_0000;
  localparam logic [31:0] DC_0  = 32'h0008_0000;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fft_butterfly_scheduler_if #(.n(NW)) bus ();
  fft_butterfly_scheduler #(.n(NW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // twiddle ROM: W^k = cos(2*pi*k/8) - j sin(2*pi*k/8), 16 fractional bits
  always_comb begin
    bus.tw_r = 32'h0;
    bus.tw_c = 32'h0;
    case (bus.tw_idx)
      2'd0: begin bus.tw_r = 32'h0001_0000; bus.tw_c = 32'h0000_0000; end
      2'd1: begin bus.tw_r = 32'd46341;     bus.tw_c = -32'd46341;    end
      2'd2: begin bus.tw_r = 32'h0000_0000; bus.tw_c = 32'hFFFF_0000; end
      default: begin bus.tw_r = -32'd46341; bus.tw_c = -32'd46341;    end
    endcase
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] xr [N];
  logic [31:0] xc [N];
  logic [31:0] res_r [N];
  logic [31:0] res_c [N];

  int  lat_max = 1;
  bit  rnd_rdy = 0;
  bit  pass_mode = 0;
  int  issue_count = 0;
  int  log_a [64];
  int  log_b [64];
  int  log_tw [64];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [31:0] obs, input real exp);
    real  diff;
    logic ok;
    diff = $itor($signed(obs)) - exp;
    ok = (diff <= TOL && diff >= -TOL);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0f", tag, $signed(obs), exp);
    end
  endtask

  function automatic int rev3(input int i);
    return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
  endfunction

  function automatic logic [127:0] bfly(input logic [31:0] ar, ac, br, bc, wr, wc);
    logic signed [63:0] pr, pi;
    logic [31:0] tr, ti;
    pr = ($signed({{32{wr[31]}}, wr}) * $signed({{32{br[31]}}, br})
        - $signed({{32{wc[31]}}, wc}) * $signed({{32{bc[31]}}, bc})) >>> D;
    pi = ($signed({{32{wr[31]}}, wr}) * $signed({{32{bc[31]}}, bc})
        + $signed({{32{wc[31]}}, wc}) * $signed({{32{br[31]}}, br})) >>> D;
    tr = pr[31:0];
    ti = pi[31:0];
    return {ar + tr, ac + ti, ar - tr, ac - ti};
  endfunction

  // butterfly unit model: accepts one issue, answers after 1..lat_max cycles
  initial begin : responder
    bit busy, issued, armed;
    int cd;
    logic [31:0] ar, ac, br, bc, wr, wc;
    busy = 0; issued = 0; armed = 0; cd = 0;
    ar = 0; ac = 0; br = 0; bc = 0; wr = 0; wc = 0;
    bus.bf_recv_rdy = 1'b0;
    bus.bf_send_val = 1'b0;
    {bus.bf_cr, bus.bf_cc, bus.bf_dr, bus.bf_dc} = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 0; issued = 0; armed = 0;
        bus.bf_send_val = 1'b0;
        bus.bf_recv_rdy = 1'b0;
      end else begin
        if (bus.bf_send_val) begin
          if (armed) begin
            bus.bf_send_val = 1'b0;
            busy = 0;
            armed = 0;
          end else armed = bus.bf_send_rdy;
        end
        if (issued) begin
          busy = 1;
          issued = 0;
          cd = $urandom_range(1, lat_max);
          bus.bf_recv_rdy = 1'b0;
        end
        if (busy && !bus.bf_send_val) begin
          cd--;
          if (cd == 0) begin
            if (pass_mode) {bus.bf_cr, bus.bf_cc, bus.bf_dr, bus.bf_dc} = {ar, ac, br, bc};
            else {bus.bf_cr, bus.bf_cc, bus.bf_dr, bus.bf_dc} = bfly(ar, ac, br, bc, wr, wc);
            bus.bf_send_val = 1'b1;
            armed = bus.bf_send_rdy;
          end
        end
        if (!busy && !issued) begin
          bus.bf_recv_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
          if (bus.bf_recv_val === 1'b1 && bus.bf_recv_rdy) begin
            ar = bus.bf_ar; ac = bus.bf_ac; br = bus.bf_br; bc = bus.bf_bc;
            wr = bus.bf_wr; wc = bus.bf_wc;
            if (issue_count < 64) begin
              log_a[issue_count]  = int'(bus.bf_ar);
              log_b[issue_count]  = int'(bus.bf_br);
              log_tw[issue_count] = int'(bus.tw_idx);
            end
            issue_count++;
            issued = 1;
          end
        end
      end
    end
  end

  task automatic load_samples(input bit hold_val);
    int cyc;
    for (int i = 0; i < N; i++) begin
      bus.in_r = xr[i];
      bus.in_c = xc[i];
      bus.in_val = 1'b1;
      cyc = 0;
      while (bus.in_rdy !== 1'b1 && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      if (cyc >= 2000) check("load_timeout", 64'(bus.in_rdy), 64'd1);
      @(negedge clk);
    end
    if (!hold_val) bus.in_val = 1'b0;
  endtask

  task automatic unload(input bit rnd_out);
    int got, cyc;
    bit stall;
    logic [63:0] held;
    got = 0; cyc = 0; stall = 0; held = '0;
    while (got < N && cyc < 6000) begin
      if (stall) begin
        check("out_stall_stable", {bus.out_r, bus.out_c}, held);
        stall = 0;
      end
      bus.out_rdy = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_val === 1'b1) begin
        if (bus.out_rdy) begin
          res_r[got] = bus.out_r;
          res_c[got] = bus.out_c;
          got++;
        end else begin
          held = {bus.out_r, bus.out_c};
          stall = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.out_rdy = 1'b0;
    check("out_count", 64'(got), 64'(N));
    check("out_val_after_last", 64'(bus.out_val), 64'd0);
    check("in_rdy_after_last", 64'(bus.in_rdy), 64'd1);
  endtask

  task automatic check_spectrum(input string tag);
    for (int m = 0; m < N; m++) begin
      real re, im, ang;
      re = 0.0;
      im = 0.0;
      for (int i = 0; i < N; i++) begin
        ang = 2.0 * 3.14159265358979 * m * i / N;
        re += $itor($signed(xr[i])) * $cos(ang) + $itor($signed(xc[i])) * $sin(ang);
        im += $itor($signed(xc[i])) * $cos(ang) - $itor($signed(xr[i])) * $sin(ang);
      end
`ifdef FFT_SCHED_SCALE_EN
      re = re / N;
      im = im / N;
`endif
      check_near($sformatf("%s_re[%0d]", tag, m), res_r[m], re);
      check_near($sformatf("%s_im[%0d]", tag, m), res_c[m], im);
    end
  endtask

  task automatic set_impulse();
    for (int i = 0; i < N; i++) begin
      xr[i] = (i == 0) ? 32'h0001_0000 : 32'h0;
      xc[i] = 32'h0;
    end
  endtask

  task automatic set_dc();
    for (int i = 0; i < N; i++) begin
      xr[i] = 32'h0001_0000;
      xc[i] = 32'h0;
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < N; i++) begin
      xr[i] = 32'($urandom_range(0, 524288)) - 32'd262144;
      xc[i] = 32'($urandom_range(0, 524288)) - 32'd262144;
    end
  endtask

  task automatic check_impulse(input string tag);
    for (int m = 0; m < N; m++) begin
      check($sformatf("%s_r[%0d]", tag, m), 64'(res_r[m]), 64'(IMP_R));
      check($sformatf("%s_c[%0d]", tag, m), 64'(res_c[m]), 64'd0);
    end
  endtask

  task automatic check_dc(input string tag);
    for (int m = 0; m < N; m++) begin
      check($sformatf("%s_r[%0d]", tag, m), 64'(res_r[m]), (m == 0) ? 64'(DC_0) : 64'd0);
      check($sformatf("%s_c[%0d]", tag, m), 64'(res_c[m]), 64'd0);
    end
  endtask

  localparam int EXP_TOP [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  localparam int EXP_BOT [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  localparam int EXP_TW  [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  initial begin : stimulus
    int cyc;
    bus.in_val = 1'b0;
    bus.in_r = '0;
    bus.in_c = '0;
    bus.out_rdy = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_rdy", 64'(bus.in_rdy), 64'd1);
    check("rst_out_val", 64'(bus.out_val), 64'd0);
    check("rst_bf_recv_val", 64'(bus.bf_recv_val), 64'd0);
    check("rst_bf_send_rdy", 64'(bus.bf_send_rdy), 64'd0);
    check("rst_tw_idx", 64'(bus.tw_idx), 64'd0);
    check("rst_out_r", 64'(bus.out_r), 64'd0);
    check("rst_bf_ar", 64'(bus.bf_ar), 64'd0);

    // schedule: identity butterfly, buffer slot p holds value p
    pass_mode = 1;
    issue_count = 0;
    for (int i = 0; i < N; i++) begin
      xr[i] = 32'(rev3(i));
      xc[i] = 32'h0;
    end
    load_samples(0);
    unload(0);
    check("sched_issue_count", 64'(issue_count), 64'd12);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("sched_top[%0d]", i), 64'(log_a[i]), 64'(EXP_TOP[i]));
      check($sformatf("sched_bot[%0d]", i), 64'(log_b[i]), 64'(EXP_BOT[i]));
      check($sformatf("sched_tw[%0d]", i), 64'(log_tw[i]), 64'(EXP_TW[i]));
    end
    for (int m = 0; m < N; m++) check($sformatf("sched_out[%0d]", m), 64'(res_r[m]), 64'(m));
    pass_mode = 0;

    // impulse and DC
    set_impulse();
    load_samples(0);
    unload(0);
    check_impulse("impulse");
    set_dc();
    load_samples(0);
    unload(0);
    check_dc("dc");

    // backpressure on every handshake with random data
    rnd_rdy = 1;
    lat_max = 20;
    set_random();
    issue_count = 0;
    load_samples(0);
    unload(1);
    check("bp_issue_count", 64'(issue_count), 64'd12);
    check_spectrum("bp");

    // reset during stage 1
    set_impulse();
    issue_count = 0;
    load_samples(0);
    cyc = 0;
    while (issue_count < 5 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 3000) check("stage1_timeout", 64'(issue_count), 64'd5);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_rdy", 64'(bus.in_rdy), 64'd1);
    check("midrst_out_val", 64'(bus.out_val), 64'd0);
    check("midrst_bf_recv_val", 64'(bus.bf_recv_val), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    load_samples(0);
    unload(1);
    check_impulse("post_rst_impulse");

    // back-to-back with in_val held high across the unload
    rnd_rdy = 0;
    lat_max = 3;
    set_random();
    load_samples(1);
    bus.in_r = 32'h0001_0000;
    bus.in_c = 32'h0;
    unload(0);
    check_spectrum("b2b_first");
    set_dc();
    load_samples(0);
    unload(0);
    check_dc("b2b_second");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
